decoder_frame_ctrl: RTL and testbench

Sequencer for the combinational (8,4) soft-decision `decoder`. It accepts 6-bit signed soft samples serially through a valid/ready handshake and assembles them into an 8-sample codeword register that drives the decoder's `r[0:7]`. It then captures the decoder's 4-bit message into a small output FIFO, which is drained through a second valid/ready handshake. It sits between the demodulator sample stream and the message sink, and owns framing, resync and backpressure for the decoder.

---
 rtl/decoder_frame_ctrl.sv | 142 ++++++++++++++
 tb/tb_decoder_frame_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_frame_ctrl.sv
// Frame sequencer for the (8,4) soft-decision decoder: serial sample framing, resync and output FIFO.
// Define DEC_FRAME_CNT_EN to add the frame_cnt delivered-frame counter.
module decoder_frame_ctrl #(
   parameter int OUT_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   input  logic signed [5:0] s_data,
   input  logic              s_last,
   output logic              s_ready,
   input  logic              abort,
   output logic signed [5:0] dec_r [0:7],
   input  logic [3:0]        dec_m,
   output logic              m_valid,
   output logic [3:0]        m_data,
   input  logic              m_ready,
   output logic              frm_err
`ifdef DEC_FRAME_CNT_EN
   ,
   output logic [15:0]       frame_cnt
`endif
);

   localparam int AW = $clog2(OUT_DEPTH);

   typedef enum logic [1:0] {FILL, DECODE, HUNT} state_t;

   state_t     state_reg, state_next;
   logic [2:0] idx_reg, idx_next;
   logic       frm_err_reg, frm_err_next;
   logic       accept, wr_en, push, pop, fifo_full;
   logic [AW:0] wr_ptr_reg, rd_ptr_reg;
   logic [3:0] fifo_mem [OUT_DEPTH];

   assign s_ready   = !reset && (state_reg != DECODE);
   assign accept    = s_valid && s_ready;
   assign fifo_full = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign m_valid   = (wr_ptr_reg != rd_ptr_reg);
   assign m_data    = m_valid ? fifo_mem[rd_ptr_reg[AW-1:0]] : 4'd0;
   // Push depends only on registered state, never on m_ready.
   assign push      = (state_reg == DECODE) && !fifo_full;
   assign pop       = m_valid && m_ready;
   assign frm_err   = frm_err_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= FILL;
         idx_reg     <= 3'd0;
         frm_err_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         frm_err_reg <= frm_err_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      frm_err_next = 1'b0;
      wr_en        = 1'b0;
      case (state_reg)
         FILL: begin
            if (abort) begin
               idx_next = 3'd0;
            end else if (accept) begin
               wr_en = 1'b1;
               if (s_last && idx_reg == 3'd7) begin
                  state_next = DECODE;
                  idx_next   = 3'd0;
               end else if (s_last) begin
                  frm_err_next = 1'b1;
                  idx_next     = 3'd0;
               end else if (idx_reg == 3'd7) begin
                  frm_err_next = 1'b1;
                  idx_next     = 3'd0;
                  state_next   = HUNT;
               end else begin
                  idx_next = idx_reg + 3'd1;
               end
            end
         end
         HUNT: begin
            if (abort || (accept && s_last)) begin
               state_next = FILL;
               idx_next   = 3'd0;
            end
         end
         DECODE: begin
            if (!fifo_full) begin
               state_next = FILL;
               idx_next   = 3'd0;
            end
         end
         default: begin
            state_next = FILL;
            idx_next   = 3'd0;
         end
      endcase
   end

   // One register per codeword position; not cleared between frames.
   for (genvar gi = 0; gi < 8; gi++) begin : g_entry
      logic signed [5:0] entry_reg;
      always_ff @(posedge clk) begin
         if (reset)
            entry_reg <= 6'sd0;
         else if (wr_en && idx_reg == 3'(gi))
            entry_reg <= s_data;
      end
      assign dec_r[gi] = entry_reg;
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr_reg[AW-1:0]] <= dec_m;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

`ifdef DEC_FRAME_CNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         frame_cnt <= 16'd0;
      else if (pop)
         frame_cnt <= frame_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_decoder_frame_ctrl.sv
// Directed bench for decoder_frame_ctrl; a hard-decision stub stands in for the decoder.
module tb_decoder_frame_ctrl;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              s_valid = 1'b0;
   logic signed [5:0] s_data = 6'sd0;
   logic              s_last = 1'b0;
   logic              s_ready;
   logic              abort = 1'b0;
   logic signed [5:0] dec_r [0:7];
   logic [3:0]        dec_m;
   logic              m_valid;
   logic [3:0]        m_data;
   logic              m_ready = 1'b1;
   logic              frm_err;
`ifdef DEC_FRAME_CNT_EN
   logic [15:0]       frame_cnt;
`endif

   int tests_run = 0;
   int tests_failed = 0;
   int err_cnt = 0;
   int cyc = 0;
   int got_q [$];
   int exp_q [$];

   // Stub decoder: message bit i is the hard decision (non-negative -> 1) of r[i].
   assign dec_m = {~dec_r[3][5], ~dec_r[2][5], ~dec_r[1][5], ~dec_r[0][5]};

   decoder_frame_ctrl #(.OUT_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
      .s_ready(s_ready), .abort(abort), .dec_r(dec_r), .dec_m(dec_m),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .frm_err(frm_err)
`ifdef DEC_FRAME_CNT_EN
      , .frame_cnt(frame_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset && m_valid && m_ready) begin
         got_q.push_back(int'(m_data));
         $display("[TB] pop msg=%h at cycle %0d", m_data, cyc);
      end
      if (frm_err) err_cnt++;
   end

   // Frames: stub message = {r3>=0, r2>=0, r1>=0, r0>=0}
   int frames [4][8] = '{
      '{ 10,  -5,  3, -1, 7, 7, 7, 7},   // 0101
      '{-32,  31, -1,  0, 4, 4, 4, 4},   // 1010
      '{ -3,  -3, -3, -3, 5, 5, 5, 5},   // 0000
      '{  1,  -1, -1,  1, 2, 2, 2, 2}    // 1001
   };
   int exp_msg [4] = '{5, 10, 0, 9};

   task automatic check(input string tag, input int obs, input int exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end else begin
         $display("[TB] ok %s = %0d", tag, obs);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_sample(input logic [5:0] d, input logic l);
      bit ok = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge clk);
         ok = s_ready;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (!ok) check("accept_timeout", 0, 1);
   endtask

   task automatic send_frame(input int f);
      for (int k = 0; k < 8; k++) send_sample(6'(frames[f][k]), k == 7);
   endtask

   task automatic check_msgs(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_msg%0d", tag, i), got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int c0, e0;
      // Reset state
      idle(3);
      @(negedge clk);
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_frm_err", frm_err, 0);
      check("rst_dec_r0", dec_r[0], 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_s_ready", s_ready, 1);
      @(posedge clk); #1;

      // Single frame of +10
      for (int k = 0; k < 8; k++) send_sample(6'sd10, k == 7);
      @(negedge clk);
      check("single_m_valid_T1", m_valid, 0);
      check("single_s_ready_T1", s_ready, 0);
      @(negedge clk);
      check("single_m_valid_T2", m_valid, 1);
      check("single_m_data", m_data, 15);
      exp_q.push_back(15);
      idle(3);
      check("single_frm_err", err_cnt, 0);
      check_msgs("single");

      // Streaming with throughput
      c0 = cyc;
      for (int f = 0; f < 4; f++) begin
         send_frame(f);
         exp_q.push_back(exp_msg[f]);
      end
      check("stream_cycles", cyc - c0, 35);
      idle(4);
      check_msgs("stream");

      // Short frame
      e0 = err_cnt;
      for (int k = 0; k < 5; k++) send_sample(6'sd3, k == 4);
      @(negedge clk);
      check("short_frm_err_hi", frm_err, 1);
      @(negedge clk);
      check("short_frm_err_lo", frm_err, 0);
      @(posedge clk); #1;
      send_frame(3);
      exp_q.push_back(9);
      idle(4);
      check("short_err_pulses", err_cnt - e0, 1);
      check_msgs("short");

      // Missing s_last, resync in HUNT
      e0 = err_cnt;
      for (int k = 0; k < 8; k++) send_sample(-6'sd7, 1'b0);
      for (int k = 0; k < 3; k++) send_sample(6'sd7, k == 2);
      idle(3);
      check("hunt_err_pulses", err_cnt - e0, 1);
      check("hunt_no_output", got_q.size(), 0);
      send_frame(0);
      exp_q.push_back(5);
      idle(4);
      check_msgs("hunt");

      // Backpressure
      m_ready = 1'b0;
      send_frame(1);
      send_frame(2);
      send_frame(0);
      idle(3);
      @(negedge clk);
      check("bp_s_ready", s_ready, 0);
      check("bp_m_valid", m_valid, 1);
      check("bp_head", m_data, 10);
      check("bp_no_pop", got_q.size(), 0);
      @(posedge clk); #1;
      m_ready = 1'b1;
      exp_q.push_back(10);
      exp_q.push_back(0);
      exp_q.push_back(5);
      idle(8);
      check_msgs("bp");

      // Abort after 4th sample, sample in abort cycle discarded
      for (int k = 0; k < 4; k++) send_sample(-6'sd9, 1'b0);
      abort = 1'b1;
      s_valid = 1'b1;
      s_data = 6'sd12;
      @(posedge clk); #1;
      abort = 1'b0;
      s_valid = 1'b0;
      idle(2);
      check("abort_no_output", got_q.size(), 0);
      send_frame(3);
      exp_q.push_back(9);
      idle(4);
      check_msgs("abort");

      // Reset mid-frame with one entry queued
      m_ready = 1'b0;
      send_frame(0);
      idle(2);
      @(negedge clk);
      check("rst2_queued", m_valid, 1);
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) send_sample(6'sd1, 1'b0);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      @(negedge clk);
      check("rst2_m_valid", m_valid, 0);
      check("rst2_s_ready", s_ready, 1);
      check("rst2_m_data", m_data, 0);
      @(posedge clk); #1;
      m_ready = 1'b1;
      send_frame(1);
      exp_q.push_back(10);
      idle(4);
      check_msgs("rst2");
`ifdef DEC_FRAME_CNT_EN
      check("frame_cnt", frame_cnt, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
